// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, control-bit indices and MEM/WB payload layout
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_CTRL_W  = 8;
    localparam int EXMEM_CTRL_W = 6;
    localparam int MEMWB_CTRL_W = 4;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;

    localparam int MEMWB_ALU_LSB = 0;
    localparam int MEMWB_MEM_LSB = MEMWB_ALU_LSB + XLEN;
    localparam int MEMWB_RD_LSB  = MEMWB_MEM_LSB + XLEN;
    localparam int MEMWB_DATA_W  = MEMWB_RD_LSB + REG_ADDR_W + 1;

    typedef struct packed {
        logic                  spare;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       mem_data;
        logic [XLEN-1:0]       alu_result;
    } memwb_payload_t;

    function automatic logic [MEMWB_DATA_W-1:0] memwb_pack(
        input logic [XLEN-1:0]       alu_result,
        input logic [XLEN-1:0]       mem_data,
        input logic [REG_ADDR_W-1:0] rd_addr
    );
        memwb_payload_t p;
        p.spare      = 1'b0;
        p.rd_addr    = rd_addr;
        p.mem_data   = mem_data;
        p.alu_result = alu_result;
        return p;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - single-entry holding slot with load/unload/clear
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_DATA_W,
    parameter int CTRL_W = MEMWB_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Load beats unload so a simultaneous refill keeps the slot occupied.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        ctrl_q <= ctrl_d;
        data_q <= data_d;
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic valid/ready pipeline stage with flush, optional skid and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = MEMWB_DATA_W,
    parameter int CTRL_W      = MEMWB_CTRL_W,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [CTRL_W-1:0]      in_ctrl_i,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [CTRL_W-1:0]      out_ctrl_o,
    output logic [DATA_W-1:0]      out_data_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    logic                   main_valid_q, main_valid_d;
    logic [CTRL_W-1:0]      main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]      main_data_q, main_data_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load, skid_unload, skid_clear;

    logic main_free;
    logic accept;

    assign main_free  = ~main_valid_q | out_ready_i;
    assign in_ready_o = (SKID != 0) ? ~skid_valid : main_free;
    assign accept     = in_valid_i & in_ready_o;

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .clear_i  (skid_clear),
                .load_i   (skid_load),
                .unload_i (skid_unload),
                .ctrl_i   (in_ctrl_i),
                .data_i   (in_data_i),
                .valid_o  (skid_valid),
                .ctrl_o   (skid_ctrl),
                .data_o   (skid_data)
            );
        end else begin : g_no_skid
            logic unused_skid;
            assign skid_valid  = 1'b0;
            assign skid_ctrl   = '0;
            assign skid_data   = '0;
            assign unused_skid = ^{skid_load, skid_unload, skid_clear};
        end
    endgenerate

    // Bubbles always carry a zero control bundle; payload only moves on a real load.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = flush_i;
        if (flush_i) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl;
                main_data_d  = skid_data;
                skid_unload  = 1'b1;
                skid_load    = accept;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl_i;
                main_data_d  = in_data_i;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready_i && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid_o = main_valid_q;
    assign out_ctrl_o  = main_ctrl_q;
    assign out_data_o  = main_data_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg in skid and non-skid modes
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [3:0]  in_ctrl;
    logic [69:0] in_data;

    logic        rdy_s, vld_s, rdy_c, vld_c;
    logic [3:0]  ctrl_s, ctrl_c;
    logic [69:0] data_s, data_c;
    logic [2:0]  stall_s;
    logic [15:0] stall_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(70), .CTRL_W(4), .SKID(1), .STALL_CNT_W(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy_s),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(vld_s), .out_ready_i(out_ready),
        .out_ctrl_o(ctrl_s), .out_data_o(data_s), .stall_cnt_o(stall_s)
    );

    pipe_stage_reg #(.DATA_W(70), .CTRL_W(4), .SKID(0), .STALL_CNT_W(16)) dut_c (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy_c),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(vld_c), .out_ready_i(out_ready),
        .out_ctrl_o(ctrl_c), .out_data_o(data_c), .stall_cnt_o(stall_c)
    );

    // Reference: an ordered FIFO of capacity 2 (skid) or 1 (no skid).
    logic [73:0] q_s[$];
    logic [73:0] q_c[$];
    logic [69:0] last_s = '0, last_c = '0;
    int          cnt_s = 0, cnt_c = 0;
    bit          acc_s, con_s, acc_c, con_c;

    always @(posedge clk) begin
        if (rst) begin
            q_s.delete(); q_c.delete();
            last_s = '0; last_c = '0; cnt_s = 0; cnt_c = 0;
        end else begin
            acc_s = in_valid && (q_s.size() < 2);
            con_s = (q_s.size() > 0) && out_ready;
            acc_c = in_valid && (out_ready || q_c.size() == 0);
            con_c = (q_c.size() > 0) && out_ready;
            if (q_s.size() > 0 && !out_ready && cnt_s < 7) cnt_s++;
            if (q_c.size() > 0 && !out_ready && cnt_c < 65535) cnt_c++;
            if (flush) begin
                q_s.delete(); q_c.delete();
            end else begin
                if (con_s) void'(q_s.pop_front());
                if (acc_s) q_s.push_back({in_ctrl, in_data});
                if (con_c) void'(q_c.pop_front());
                if (acc_c) q_c.push_back({in_ctrl, in_data});
            end
            if (q_s.size() > 0) last_s = q_s[0][69:0];
            if (q_c.size() > 0) last_c = q_c[0][69:0];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_ctrl = 4'h0; in_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_data = 70'h3_DEAD_BEEF_1234_5678;
        in_valid = 1'b1; in_ctrl = 4'hF;
        cyc();
        do_reset();
        #1;
        checks++; if (vld_s !== 1'b0 || ctrl_s !== 4'h0 || data_s !== 70'h0 || stall_s !== 3'h0)
            begin errors++; $display("FAIL reset_s got v=%b c=%h d=%h s=%0d exp 0/0/0/0", vld_s, ctrl_s, data_s, stall_s); end
        checks++; if (vld_c !== 1'b0 || ctrl_c !== 4'h0 || data_c !== 70'h0 || stall_c !== 16'h0)
            begin errors++; $display("FAIL reset_c got v=%b c=%h d=%h s=%0d exp 0/0/0/0", vld_c, ctrl_c, data_c, stall_c); end
        checks++; if (rdy_s !== 1'b1 || rdy_c !== 1'b1)
            begin errors++; $display("FAIL reset_ready got s=%b c=%b exp 1/1", rdy_s, rdy_c); end
    endtask

    task automatic test_pass_through();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 70'(8'h11 + i); in_ctrl = 4'(i + 1);
            cyc();
            checks++; if (vld_s !== 1'b1 || data_s !== 70'(8'h11 + i) || ctrl_s !== 4'(i + 1) || rdy_s !== 1'b1)
                begin errors++; $display("FAIL pass_s[%0d] got v=%b d=%h c=%h r=%b exp 1/%h/%h/1", i, vld_s, data_s, ctrl_s, rdy_s, 8'h11 + i, i + 1); end
            checks++; if (vld_c !== 1'b1 || data_c !== 70'(8'h11 + i) || ctrl_c !== 4'(i + 1))
                begin errors++; $display("FAIL pass_c[%0d] got v=%b d=%h c=%h exp 1/%h/%h", i, vld_c, data_c, ctrl_c, 8'h11 + i, i + 1); end
        end
        in_valid = 1'b0;
        cyc();
        checks++; if (vld_s !== 1'b0 || ctrl_s !== 4'h0 || vld_c !== 1'b0 || ctrl_c !== 4'h0)
            begin errors++; $display("FAIL pass_drain got vs=%b cs=%h vc=%b cc=%h exp 0/0/0/0", vld_s, ctrl_s, vld_c, ctrl_c); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 70'hA; in_ctrl = 4'h1;
        cyc();
        checks++; if (vld_s !== 1'b1 || data_s !== 70'hA || rdy_s !== 1'b1)
            begin errors++; $display("FAIL bp_a got v=%b d=%h r=%b exp 1/a/1", vld_s, data_s, rdy_s); end
        in_data = 70'hB; in_ctrl = 4'h2;
        cyc();
        checks++; if (data_s !== 70'hA || rdy_s !== 1'b0)
            begin errors++; $display("FAIL bp_skid got d=%h r=%b exp a/0", data_s, rdy_s); end
        in_data = 70'hC; in_ctrl = 4'h3;
        cyc();
        checks++; if (data_s !== 70'hA || ctrl_s !== 4'h1 || rdy_s !== 1'b0 || stall_s !== 3'd2)
            begin errors++; $display("FAIL bp_hold got d=%h c=%h r=%b s=%0d exp a/1/0/2", data_s, ctrl_s, rdy_s, stall_s); end
        out_ready = 1'b1;
        cyc();
        checks++; if (vld_s !== 1'b1 || data_s !== 70'hB || ctrl_s !== 4'h2 || rdy_s !== 1'b1)
            begin errors++; $display("FAIL bp_out_b got v=%b d=%h c=%h r=%b exp 1/b/2/1", vld_s, data_s, ctrl_s, rdy_s); end
        cyc();
        checks++; if (vld_s !== 1'b1 || data_s !== 70'hC || ctrl_s !== 4'h3)
            begin errors++; $display("FAIL bp_out_c got v=%b d=%h c=%h exp 1/c/3", vld_s, data_s, ctrl_s); end
        in_valid = 1'b0;
        cyc();
        checks++; if (vld_s !== 1'b0 || ctrl_s !== 4'h0 || stall_s !== 3'd2)
            begin errors++; $display("FAIL bp_empty got v=%b c=%h s=%0d exp 0/0/2", vld_s, ctrl_s, stall_s); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 70'hA1; in_ctrl = 4'h5;
        cyc();
        in_data = 70'hB2; in_ctrl = 4'h6;
        cyc();
        in_data = 70'hD4; in_ctrl = 4'h7; flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (vld_s !== 1'b0 || ctrl_s !== 4'h0 || rdy_s !== 1'b1 || data_s !== 70'hA1)
            begin errors++; $display("FAIL flush_s got v=%b c=%h r=%b d=%h exp 0/0/1/a1", vld_s, ctrl_s, rdy_s, data_s); end
        checks++; if (vld_c !== 1'b0 || ctrl_c !== 4'h0)
            begin errors++; $display("FAIL flush_c got v=%b c=%h exp 0/0", vld_c, ctrl_c); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 70'hE5; in_ctrl = 4'h9;
        cyc();
        checks++; if (vld_s !== 1'b1 || data_s !== 70'hE5 || ctrl_s !== 4'h9)
            begin errors++; $display("FAIL flush_next got v=%b d=%h c=%h exp 1/e5/9", vld_s, data_s, ctrl_s); end
        in_valid = 1'b0;
        cyc();
        checks++; if (vld_s !== 1'b0 || data_s !== 70'hE5)
            begin errors++; $display("FAIL flush_gone got v=%b d=%h exp 0/e5", vld_s, data_s); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 70'h51; in_ctrl = 4'h1;
        cyc();
        in_data = 70'h52; in_ctrl = 4'h2;
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        checks++; if (stall_s !== 3'd5 || rdy_s !== 1'b0)
            begin errors++; $display("FAIL rst_stall_pre got s=%0d r=%b exp 5/0", stall_s, rdy_s); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (vld_s !== 1'b0 || ctrl_s !== 4'h0 || data_s !== 70'h0 || stall_s !== 3'd0 || rdy_s !== 1'b1)
            begin errors++; $display("FAIL rst_stall got v=%b c=%h d=%h s=%0d r=%b exp 0/0/0/0/1", vld_s, ctrl_s, data_s, stall_s, rdy_s); end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 70'h77; in_ctrl = 4'h4;
        cyc();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++; if (stall_s !== 3'((k < 7) ? k : 7))
                begin errors++; $display("FAIL stall_sat[%0d] got %0d exp %0d", k, stall_s, (k < 7) ? k : 7); end
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        checks++; if (stall_s !== 3'd7 || vld_s !== 1'b0)
            begin errors++; $display("FAIL stall_flush got s=%0d v=%b exp 7/0", stall_s, vld_s); end
    endtask

    task automatic test_bubble();
        do_reset();
        in_valid = 1'b0; in_ctrl = 4'hF; in_data = 70'h1234;
        for (int k = 0; k < 3; k++) begin
            out_ready = k[0];
            cyc();
            checks++; if (ctrl_s !== 4'h0 || ctrl_c !== 4'h0 || vld_s !== 1'b0 || vld_c !== 1'b0)
                begin errors++; $display("FAIL bubble[%0d] got cs=%h cc=%h vs=%b vc=%b exp 0/0/0/0", k, ctrl_s, ctrl_c, vld_s, vld_c); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  ec;
        logic [15:0] ec_stall;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ctrl   = 4'($urandom);
            in_data   = 70'({$urandom(), $urandom(), $urandom()});
            #1;
            ec = (q_s.size() > 0) ? q_s[0][73:70] : 4'h0;
            checks++; if (vld_s !== (q_s.size() > 0) || ctrl_s !== ec || data_s !== last_s)
                begin errors++; $display("FAIL rand_out_s[%0d] got v=%b c=%h d=%h exp %b/%h/%h", n, vld_s, ctrl_s, data_s, q_s.size() > 0, ec, last_s); end
            checks++; if (rdy_s !== (q_s.size() < 2) || stall_s !== 3'(cnt_s))
                begin errors++; $display("FAIL rand_ctl_s[%0d] got r=%b s=%0d exp %b/%0d", n, rdy_s, stall_s, q_s.size() < 2, cnt_s); end
            ec = (q_c.size() > 0) ? q_c[0][73:70] : 4'h0;
            checks++; if (vld_c !== (q_c.size() > 0) || ctrl_c !== ec || data_c !== last_c)
                begin errors++; $display("FAIL rand_out_c[%0d] got v=%b c=%h d=%h exp %b/%h/%h", n, vld_c, ctrl_c, data_c, q_c.size() > 0, ec, last_c); end
            ec_stall = 16'(cnt_c);
            checks++; if (rdy_c !== (out_ready || q_c.size() == 0) || stall_c !== ec_stall)
                begin errors++; $display("FAIL rand_ctl_c[%0d] got r=%b s=%0d exp %b/%0d", n, rdy_c, stall_c, out_ready || q_c.size() == 0, ec_stall); end
            cyc();
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        cyc();
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_flush();
        test_reset_mid_stall();
        test_stall_saturate();
        test_bubble();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
